// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default frame width and clog2,
// used by the TX/RX state machines and the transmitter arbiter.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after pointer,
// wrapping past the top requester back to 0.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      pointer,
  output logic [NUM_REQ-1:0] onehot,
  output logic [PW-1:0]      index,
  output logic               valid
);

  always_comb begin : search
    int idx;
    onehot = '0;
    index  = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(pointer) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!valid && req[idx]) begin
        valid       = 1'b1;
        onehot[idx] = 1'b1;
        index       = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ requesters,
// with an inter-frame gap and a done-watchdog against a hung transmitter.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = DATA_BITS_DEF,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           bclk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic                           txd_startH,
  output logic [DATA_BITS-1:0]           tx_data,
  input  logic                           txd_done,
  output logic                           timeout_err
);

  localparam int PW = clog2(NUM_REQ);
  localparam int WW = clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (clog2(GAP_CYCLES + 1) > 0) ? clog2(GAP_CYCLES + 1) : 1;

  localparam logic [PW-1:0] PTR_LAST  = PW'(NUM_REQ - 1);
  localparam logic [WW-1:0] WD_EXPIRE = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [1:0]    ST_AFTER  = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
  localparam logic          BUSY_AFTER = (GAP_CYCLES != 0);

  logic [1:0]         state;
  logic [PW-1:0]      ptr;
  logic [WW-1:0]      wd;
  logic [GW-1:0]      gap_cnt;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [PW-1:0]      pick_idx;
  logic               pick_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .req     (req),
    .pointer (ptr),
    .onehot  (pick_onehot),
    .index   (pick_idx),
    .valid   (pick_valid)
  );

  always_ff @(posedge bclk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      wd          <= '0;
      gap_cnt     <= '0;
      ack         <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      txd_startH  <= 1'b0;
      tx_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      ack         <= '0;
      txd_startH  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state   <= ST_START;
            grant   <= pick_onehot;
            busy    <= 1'b1;
            tx_data <= req_data[int'(pick_idx)*DATA_BITS +: DATA_BITS];
            ptr     <= (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
          end
        end
        ST_START: begin
          txd_startH <= 1'b1;
          wd         <= '0;
          state      <= ST_BUSY;
        end
        ST_BUSY: begin
          if (wd != WD_MAX) wd <= wd + 1'b1;
          // done takes priority over a simultaneous watchdog expiry
          if (txd_done) begin
            ack     <= grant;
            grant   <= '0;
            gap_cnt <= '0;
            busy    <= BUSY_AFTER;
            state   <= ST_AFTER;
          end else if (wd == WD_EXPIRE) begin
            timeout_err <= 1'b1;
            grant       <= '0;
            gap_cnt     <= '0;
            busy        <= BUSY_AFTER;
            state       <= ST_AFTER;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a transmitter model answers start
// pulses with done after a programmable delay; a round-robin model predicts grants.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int DB    = 8;
  localparam int GAP   = 2;
  localparam int TO    = 16;
  localparam int LIMIT = 200;

  localparam int W_GRANT = 0;
  localparam int W_START = 1;
  localparam int W_ACK   = 2;
  localparam int W_IDLE  = 3;
  localparam int W_TOUT  = 4;

  logic          bclk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DB-1:0] req_data;
  logic [N-1:0]  ack;
  logic [N-1:0]  grant;
  logic          busy;
  logic          txd_startH;
  logic [DB-1:0] tx_data;
  logic          txd_done;
  logic          timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int model_ptr = 0;
  int done_delay = 10;
  bit tx_model_en = 1'b1;
  int tx_cnt = -1;

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .DATA_BITS      (DB),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .bclk        (bclk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .grant       (grant),
    .busy        (busy),
    .txd_startH  (txd_startH),
    .tx_data     (tx_data),
    .txd_done    (txd_done),
    .timeout_err (timeout_err)
  );

  always #5 bclk = ~bclk;

  // Transmitter model: done is high for one cycle, done_delay cycles after start is seen.
  initial begin
    txd_done = 1'b0;
    forever begin
      @(posedge bclk);
      #2;
      if (txd_done) txd_done = 1'b0;
      if (rst) begin
        tx_cnt = -1;
      end else begin
        if (tx_cnt > 0) begin
          tx_cnt = tx_cnt - 1;
          if (tx_cnt == 0) begin
            txd_done = tx_model_en;
            tx_cnt   = -1;
          end
        end
        if (txd_startH === 1'b1) tx_cnt = done_delay;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot_of(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge bclk);
    #1;
  endtask

  task automatic wait_cond(input int which, output int cycles);
    bit hit;
    cycles = -1;
    for (int c = 0; c < LIMIT; c++) begin
      case (which)
        W_GRANT: hit = (grant !== '0);
        W_START: hit = (txd_startH === 1'b1);
        W_ACK:   hit = (ack !== '0);
        W_IDLE:  hit = (busy === 1'b0);
        W_TOUT:  hit = (timeout_err === 1'b1);
        default: hit = 1'b1;
      endcase
      if (hit) begin
        cycles = c;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    req_data = '0;
    step();
    step();
    n_tests++; if (grant !== '0) begin n_fail++; $display("[TB] FAIL reset_grant: got %b want 0", grant); end
    n_tests++; if (ack !== '0) begin n_fail++; $display("[TB] FAIL reset_ack: got %b want 0", ack); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (txd_startH !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_start: got %b want 0", txd_startH); end
    n_tests++; if (tx_data !== '0) begin n_fail++; $display("[TB] FAIL reset_txdata: got %h want 0", tx_data); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_timeout: got %b want 0", timeout_err); end
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_single();
    int c;
    int p;
    logic [DB-1:0] d2;
    tx_model_en = 1'b1;
    done_delay  = 10;
    req_data = 32'($urandom());
    req_data[2*DB +: DB] = 8'hA5;
    req = 4'b0100;
    p = model_pick(req, model_ptr);
    model_ptr = (p + 1) % N;
    step();
    n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("[TB] FAIL single_grant: got %b want 0100", grant); end
    n_tests++; if (tx_data !== 8'hA5) begin n_fail++; $display("[TB] FAIL single_txdata: got %h want a5", tx_data); end
    n_tests++; if (txd_startH !== 1'b0) begin n_fail++; $display("[TB] FAIL single_start_early: got %b want 0", txd_startH); end
    step();
    n_tests++; if (txd_startH !== 1'b1) begin n_fail++; $display("[TB] FAIL single_start_latency: got %b want 1", txd_startH); end
    c = -1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (ack !== '0) begin
        c = k;
        break;
      end
    end
    n_tests++; if (c != done_delay + 1) begin n_fail++; $display("[TB] FAIL single_ack_cycle: got %0d want %0d", c, done_delay + 1); end
    n_tests++; if (ack !== 4'b0100 || grant !== '0) begin n_fail++; $display("[TB] FAIL single_ack_value: got ack %b grant %b want ack 0100 grant 0000", ack, grant); end
    d2 = 8'($urandom());
    req_data[2*DB +: DB] = d2;
    p = model_pick(req, model_ptr);
    model_ptr = (p + 1) % N;
    c = 0;
    while (txd_startH !== 1'b1 && c < 40) begin
      step();
      c++;
    end
    n_tests++; if (c != GAP + 2) begin n_fail++; $display("[TB] FAIL single_gap: got %0d cycles ack-to-start want %0d", c, GAP + 2); end
    n_tests++; if (tx_data !== d2 || grant !== 4'b0100) begin n_fail++; $display("[TB] FAIL single_second: got data %h grant %b want data %h grant 0100", tx_data, grant, d2); end
    wait_cond(W_ACK, c);
    req = '0;
    wait_cond(W_IDLE, c);
    n_tests++; if (c < 0) begin n_fail++; $display("[TB] FAIL single_drain: got no idle want idle within %0d", LIMIT); end
  endtask

  task automatic test_fairness();
    int c;
    int exp;
    logic [N-1:0] expg;
    logic [N-1:0] prev;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_ptr = 0;
    tx_model_en = 1'b1;
    req_data = 32'($urandom());
    req = 4'b1111;
    prev = '0;
    for (int f = 0; f < 5; f++) begin
      done_delay = $urandom_range(12, 2);
      exp = model_pick(req, model_ptr);
      model_ptr = (exp + 1) % N;
      expg = onehot_of(exp);
      wait_cond(W_GRANT, c);
      n_tests++; if (c < 0 || grant !== expg || tx_data !== req_data[exp*DB +: DB]) begin
        n_fail++; $display("[TB] FAIL fair_grant%0d: got grant %b data %h want grant %b data %h", f, grant, tx_data, expg, req_data[exp*DB +: DB]);
      end
      n_tests++; if (grant === prev) begin n_fail++; $display("[TB] FAIL fair_repeat%0d: got %b twice want a different requester", f, grant); end
      prev = grant;
      wait_cond(W_ACK, c);
      n_tests++; if (c < 0 || ack !== expg) begin n_fail++; $display("[TB] FAIL fair_ack%0d: got %b want %b", f, ack, expg); end
    end
    req = '0;
    wait_cond(W_IDLE, c);
  endtask

  task automatic test_random();
    int c;
    int exp;
    logic [N-1:0] r;
    logic [N-1:0] expg;
    tx_model_en = 1'b1;
    for (int f = 0; f < 10; f++) begin
      r = N'($urandom_range(15, 1));
      req_data = 32'($urandom());
      done_delay = $urandom_range(12, 2);
      exp = model_pick(r, model_ptr);
      model_ptr = (exp + 1) % N;
      expg = onehot_of(exp);
      req = r;
      wait_cond(W_GRANT, c);
      n_tests++; if (c < 0 || grant !== expg || tx_data !== req_data[exp*DB +: DB]) begin
        n_fail++; $display("[TB] FAIL rand_grant%0d: req %b got grant %b data %h want grant %b data %h", f, r, grant, tx_data, expg, req_data[exp*DB +: DB]);
      end
      wait_cond(W_ACK, c);
      n_tests++; if (c < 0 || ack !== expg) begin n_fail++; $display("[TB] FAIL rand_ack%0d: got %b want %b", f, ack, expg); end
      req = '0;
      wait_cond(W_IDLE, c);
    end
  endtask

  task automatic test_wrap();
    int c;
    int exp;
    logic [N-1:0] expg;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_ptr = 0;
    tx_model_en = 1'b1;
    done_delay = 4;
    req_data = 32'($urandom());
    req = 4'b0100;
    exp = model_pick(req, model_ptr);
    model_ptr = (exp + 1) % N;
    wait_cond(W_GRANT, c);
    n_tests++; if (c < 0 || grant !== onehot_of(exp)) begin n_fail++; $display("[TB] FAIL wrap_first: got %b want %b", grant, onehot_of(exp)); end
    wait_cond(W_ACK, c);
    req = '0;
    wait_cond(W_IDLE, c);
    req = 4'b0011;
    for (int f = 0; f < 2; f++) begin
      exp = model_pick(req, model_ptr);
      model_ptr = (exp + 1) % N;
      expg = onehot_of(exp);
      wait_cond(W_GRANT, c);
      n_tests++; if (c < 0 || grant !== expg) begin n_fail++; $display("[TB] FAIL wrap_grant%0d: got %b want %b", f, grant, expg); end
      wait_cond(W_ACK, c);
    end
    req = '0;
    wait_cond(W_IDLE, c);
  endtask

  task automatic test_watchdog();
    int c;
    int k;
    int acks;
    int exp;
    tx_model_en = 1'b0;
    done_delay = 5;
    req_data = 32'($urandom());
    req = 4'b0010;
    exp = model_pick(req, model_ptr);
    model_ptr = (exp + 1) % N;
    wait_cond(W_START, c);
    k = 0;
    acks = 0;
    while (timeout_err !== 1'b1 && k < 40) begin
      step();
      k++;
      if (ack !== '0) acks++;
    end
    n_tests++; if (k != TO) begin n_fail++; $display("[TB] FAIL wd_latency: got %0d cycles start-to-timeout want %0d", k, TO); end
    n_tests++; if (acks != 0 || ack !== '0 || grant !== '0) begin n_fail++; $display("[TB] FAIL wd_outputs: got ack %b grant %b acks %0d want all 0", ack, grant, acks); end
    tx_model_en = 1'b1;
    exp = model_pick(req, model_ptr);
    model_ptr = (exp + 1) % N;
    step();
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_pulse_width: got %b want 0", timeout_err); end
    c = 1;
    while (txd_startH !== 1'b1 && c < 40) begin
      step();
      c++;
    end
    n_tests++; if (c != GAP + 2 || grant !== onehot_of(exp)) begin n_fail++; $display("[TB] FAIL wd_resume: got %0d cycles grant %b want %0d cycles grant %b", c, grant, GAP + 2, onehot_of(exp)); end
    wait_cond(W_ACK, c);
    n_tests++; if (c < 0 || ack !== onehot_of(exp)) begin n_fail++; $display("[TB] FAIL wd_resume_ack: got %b want %b", ack, onehot_of(exp)); end
    req = '0;
    wait_cond(W_IDLE, c);
  endtask

  task automatic test_collision();
    int c;
    int k;
    int exp;
    tx_model_en = 1'b1;
    done_delay = TO - 1;
    req_data = 32'($urandom());
    req = 4'b1000;
    exp = model_pick(req, model_ptr);
    model_ptr = (exp + 1) % N;
    wait_cond(W_START, c);
    k = 0;
    while (ack === '0 && timeout_err !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    n_tests++; if (k != TO || ack !== onehot_of(exp) || timeout_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL collision: got cycle %0d ack %b err %b want cycle %0d ack %b err 0", k, ack, timeout_err, TO, onehot_of(exp));
    end
    req = '0;
    step();
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("[TB] FAIL collision_late_err: got %b want 0", timeout_err); end
    wait_cond(W_IDLE, c);
  endtask

  task automatic test_reset_mid();
    int c;
    int acks;
    int exp;
    tx_model_en = 1'b1;
    done_delay = 12;
    req_data = 32'($urandom());
    req = 4'b0010;
    wait_cond(W_START, c);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    n_tests++; if (grant !== '0 || ack !== '0 || busy !== 1'b0 || txd_startH !== 1'b0 || tx_data !== '0 || timeout_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midreset_outputs: got grant %b ack %b busy %b start %b data %h err %b want all 0", grant, ack, busy, txd_startH, tx_data, timeout_err);
    end
    rst = 1'b0;
    model_ptr = 0;
    req = 4'b1000;
    exp = model_pick(req, model_ptr);
    model_ptr = (exp + 1) % N;
    acks = 0;
    c = 0;
    while (grant === '0 && c < 40) begin
      step();
      c++;
      if (ack !== '0) acks++;
    end
    n_tests++; if (grant !== onehot_of(exp) || acks != 0 || c != 1) begin
      n_fail++; $display("[TB] FAIL midreset_restart: got grant %b after %0d cycles acks %0d want grant %b after 1 cycle acks 0", grant, c, acks, onehot_of(exp));
    end
    wait_cond(W_ACK, c);
    n_tests++; if (c < 0 || ack !== onehot_of(exp)) begin n_fail++; $display("[TB] FAIL midreset_ack: got %b want %b", ack, onehot_of(exp)); end
    req = '0;
    wait_cond(W_IDLE, c);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_fairness();
    test_random();
    test_wrap();
    test_watchdog();
    test_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
